// File: rtl/riscv_if_parcel_queue.sv
// Instruction-fetch parcel queue and aligner: buffers fetched parcels as halfwords
// and presents one complete 16/32-bit instruction per cycle. Option: RISCV_IFQ_RVC_EN.
module riscv_if_parcel_queue #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic [PARCEL_SIZE-1:0] parcel_i,
  input  logic [XLEN-1:0]        parcel_pc_i,
  input  logic                   parcel_valid_i,
  input  logic                   parcel_misaligned_i,
  input  logic                   parcel_page_fault_i,
  output logic                   queue_full_o,
  output logic [31:0]            instr_o,
  output logic [XLEN-1:0]        instr_pc_o,
  output logic                   instr_valid_o,
  output logic                   instr_is_16bit_o,
  output logic                   instr_misaligned_o,
  output logic                   instr_page_fault_o,
  input  logic                   instr_ready_i
);
  localparam int HW = PARCEL_SIZE / 16;
  localparam int OB = $clog2(HW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef RISCV_IFQ_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic [15:0]      data_q [DEPTH];
  logic [15:0]      data_d [DEPTH];
  logic [DEPTH-1:0] mis_q, mis_d, pf_q, pf_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             seed_q, seed_d;
  logic             seed_mis_q, seed_mis_d;

  logic [PW-1:0]    rd_nxt, widx;
  logic [15:0]      head, tail;
  logic             is32, have1, have2, two;
  logic             push, pop;
  logic [OB-1:0]    s;
  logic [CW-1:0]    push_n, pop_n;
  logic             unused_pc0;

  assign unused_pc0 = parcel_pc_i[0];

  // Handshakes: a parcel is taken on parcel_valid_i & ~queue_full_o & ~flush;
  // an instruction is taken on instr_valid_o & instr_ready_i. Both act at the clock edge.
  assign rd_nxt = rd_q + PW'(1);
  assign head   = data_q[rd_q];
  assign tail   = data_q[rd_nxt];
  assign have1  = (count_q != '0);
  assign have2  = (count_q >= CW'(2));
  assign is32   = RVC ? (head[1:0] == 2'b11) : 1'b1;
  assign two    = is32 & have2;

  assign queue_full_o  = (CW'(DEPTH) - count_q) < CW'(HW);
  // A faulting head is released alone so a faulting fetch cannot stall decode.
  assign instr_valid_o = have1 & (~is32 | have2 | mis_q[rd_q] | pf_q[rd_q]);
  assign instr_o       = two ? {tail, head} : {16'h0000, head};
  assign instr_pc_o    = pc_q;
  assign instr_is_16bit_o   = have1 & ~is32;
  assign instr_misaligned_o = have1 & (mis_q[rd_q] | (two & mis_q[rd_nxt]) | seed_mis_q);
  assign instr_page_fault_o = have1 & (pf_q[rd_q] | (two & pf_q[rd_nxt]));

  assign push   = parcel_valid_i & ~queue_full_o & ~flush;
  assign pop    = instr_valid_o & instr_ready_i;
  assign pop_n  = two ? CW'(2) : CW'(1);
  assign push_n = CW'(HW) - CW'(s);

  // Without RVC a seed at PC[1]=1 still starts on a word boundary.
  always_comb begin
    s = '0;
    if (seed_q) s = parcel_pc_i[OB:1];
    if (!RVC) s[0] = 1'b0;
  end

  always_comb begin
    data_d     = data_q;
    mis_d      = mis_q;
    pf_d       = pf_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    seed_d     = seed_q;
    seed_mis_d = seed_mis_q;
    widx       = '0;
    if (flush) begin
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      seed_d     = 1'b1;
      seed_mis_d = 1'b0;
    end else begin
      if (pop) begin
        rd_d       = rd_q + pop_n[PW-1:0];
        pc_d       = pc_q + (is32 ? XLEN'(4) : XLEN'(2));
        count_d    = count_q - pop_n;
        seed_mis_d = 1'b0;
      end
      if (push) begin
        for (int h = 0; h < HW; h++) begin
          if (OB'(h) >= s) begin
            widx        = wr_q + PW'(h) - PW'(s);
            data_d[widx] = parcel_i[16*h +: 16];
            mis_d[widx]  = parcel_misaligned_i;
            pf_d[widx]   = parcel_page_fault_i;
          end
        end
        wr_d    = wr_q + push_n[PW-1:0];
        count_d = count_d + push_n;
        if (seed_q) begin
          pc_d       = {parcel_pc_i[XLEN-1:OB+1], s, 1'b0};
          seed_d     = 1'b0;
          seed_mis_d = ~RVC & parcel_pc_i[1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      mis_q      <= '0;
      pf_q       <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      pc_q       <= '0;
      seed_q     <= 1'b1;
      seed_mis_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      mis_q      <= mis_d;
      pf_q       <= pf_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      seed_q     <= seed_d;
      seed_mis_q <= seed_mis_d;
    end
  end
endmodule

// File: tb/tb_riscv_if_parcel_queue.sv
// Bench for riscv_if_parcel_queue: queue-of-halfwords reference model checked every
// cycle, plus directed vectors with literal expectations for both RVC builds.
module tb_riscv_if_parcel_queue;
  localparam int XLEN = 32;
  localparam int PARCEL_SIZE = 32;
  localparam int DEPTH = 8;
  localparam int HW = PARCEL_SIZE / 16;
`ifdef RISCV_IFQ_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic [PARCEL_SIZE-1:0] parcel_i = '0;
  logic [XLEN-1:0] parcel_pc_i = '0;
  logic parcel_valid_i = 1'b0;
  logic parcel_misaligned_i = 1'b0;
  logic parcel_page_fault_i = 1'b0;
  logic instr_ready_i = 1'b0;
  logic queue_full_o;
  logic [31:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic instr_valid_o, instr_is_16bit_o, instr_misaligned_o, instr_page_fault_o;

  int vectors = 0;
  int miscompares = 0;

  riscv_if_parcel_queue #(.XLEN(XLEN), .PARCEL_SIZE(PARCEL_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .parcel_i(parcel_i), .parcel_pc_i(parcel_pc_i), .parcel_valid_i(parcel_valid_i),
    .parcel_misaligned_i(parcel_misaligned_i), .parcel_page_fault_i(parcel_page_fault_i),
    .queue_full_o(queue_full_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o), .instr_is_16bit_o(instr_is_16bit_o),
    .instr_misaligned_o(instr_misaligned_o), .instr_page_fault_o(instr_page_fault_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  // Model: queue of {page_fault, misaligned, data[15:0]} halfwords.
  logic [17:0] mq[$];
  logic [XLEN-1:0] m_pc;
  bit m_seed, m_seed_mis;

  function automatic int m_len();
    if (mq.size() == 0) return 0;
    if (RVC && mq[0][1:0] != 2'b11) return 1;
    return 2;
  endfunction

  function automatic bit m_valid();
    int n;
    n = m_len();
    if (n == 0) return 1'b0;
    return (mq.size() >= n) || mq[0][16] || mq[0][17];
  endfunction

  function automatic logic [31:0] m_instr();
    if (m_len() == 1) return {16'h0000, mq[0][15:0]};
    return {mq[1][15:0], mq[0][15:0]};
  endfunction

  function automatic bit m_fault(input int b);
    bit f;
    f = mq[0][b];
    if (m_len() == 2 && mq.size() >= 2) f = f | mq[1][b];
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_pc = '0;
      m_seed = 1'b1;
      m_seed_mis = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_seed = 1'b1;
      m_seed_mis = 1'b0;
    end else begin
      bit acc;
      int s;
      int n;
      acc = parcel_valid_i && ((DEPTH - mq.size()) >= HW);
      if (m_valid() && instr_ready_i) begin
        n = m_len();
        m_pc = m_pc + XLEN'(2 * n);
        for (int i = 0; i < n; i++) if (mq.size() > 0) void'(mq.pop_front());
        m_seed_mis = 1'b0;
      end
      if (acc) begin
        s = m_seed ? int'((parcel_pc_i >> 1) % HW) : 0;
        if (!RVC) s = s & ~1;
        for (int h = s; h < HW; h++)
          mq.push_back({parcel_page_fault_i, parcel_misaligned_i, parcel_i[16*h +: 16]});
        if (m_seed) begin
          m_pc = (parcel_pc_i & ~XLEN'(2 * HW - 1)) | XLEN'(2 * s);
          m_seed_mis = !RVC && parcel_pc_i[1];
          m_seed = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("full", queue_full_o, (DEPTH - mq.size()) < HW);
      chk("valid", instr_valid_o, m_valid());
      if (m_valid()) begin
        chk("pc", instr_pc_o, m_pc);
        chk("is16", instr_is_16bit_o, m_len() == 1);
        if (m_len() == 1 || mq.size() >= 2) chk("instr", instr_o, m_instr());
        chk("mis", instr_misaligned_o, m_fault(16) | m_seed_mis);
        chk("pf", instr_page_fault_o, m_fault(17));
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input logic [31:0] pc,
                       input bit mis, input bit pf, input bit rdy, input bit fl);
    parcel_valid_i = v;
    parcel_i = d;
    parcel_pc_i = pc;
    parcel_misaligned_i = mis;
    parcel_page_fault_i = pf;
    instr_ready_i = rdy;
    flush = fl;
    @(posedge clk);
    @(negedge clk);
    parcel_valid_i = 1'b0;
    parcel_misaligned_i = 1'b0;
    parcel_page_fault_i = 1'b0;
    instr_ready_i = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle_pop(input int n);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
  endtask

  logic [31:0] tbl [6];

  initial begin
    tbl[0] = 32'h0000_0013; tbl[1] = 32'h4501_4501; tbl[2] = 32'h0013_4501;
    tbl[3] = 32'h0001_0000; tbl[4] = 32'h8082_0093; tbl[5] = 32'h0013_0013;

    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_is16", instr_is_16bit_o, 1'b0);
    chk("rst_mis", instr_misaligned_o, 1'b0);
    chk("rst_pf", instr_page_fault_o, 1'b0);
    chk("rst_full", queue_full_o, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    // First 32-bit instruction after reset.
    drive(1, 32'h0000_0013, 32'h200, 0, 0, 0, 0);
    chk("t1_valid", instr_valid_o, 1'b1);
    chk("t1_instr", instr_o, 32'h0000_0013);
    chk("t1_pc", instr_pc_o, 32'h200);
    chk("t1_is16", instr_is_16bit_o, 1'b0);
    idle_pop(1);
    chk("t1_empty", instr_valid_o, 1'b0);

    // Compressed followed by a straddling 32-bit instruction.
    drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
    drive(1, 32'h0013_4501, 32'h300, 0, 0, 0, 0);
    chk("t2_instr", instr_o, RVC ? 32'h0000_4501 : 32'h0013_4501);
    chk("t2_is16", instr_is_16bit_o, RVC);
    chk("t2_pc", instr_pc_o, 32'h300);
    idle_pop(1);
    chk("t2_wait", instr_valid_o, 1'b0);
    drive(1, 32'h0001_0000, 32'h304, 0, 0, 0, 0);
    chk("t2_instr2", instr_o, RVC ? 32'h0000_0013 : 32'h0001_0000);
    chk("t2_pc2", instr_pc_o, RVC ? 32'h302 : 32'h304);
    idle_pop(3);

    // Branch target at PC[1]=1.
    drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
    drive(1, 32'hABCD_0001, 32'h402, 0, 0, 0, 0);
    chk("t3_pc", instr_pc_o, RVC ? 32'h402 : 32'h400);
    chk("t3_instr", instr_o, RVC ? 32'h0000_ABCD : 32'hABCD_0001);
    chk("t3_mis", instr_misaligned_o, !RVC);
    idle_pop(1);
    drive(1, 32'h0000_0013, 32'h404, 0, 0, 0, 0);
    chk("t3_mis_clr", instr_misaligned_o, 1'b0);
    chk("t3_pc2", instr_pc_o, 32'h404);
    idle_pop(1);

    // Fill to full; the fifth parcel must be dropped.
    drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h0000_0013 | (i << 20), 32'h500 + 4 * i, 0, 0, 0, 0);
      if (i == 2) chk("t4_not_full", queue_full_o, 1'b0);
    end
    chk("t4_full", queue_full_o, 1'b1);
    drive(1, 32'hDEAD_0013, 32'h510, 0, 0, 0, 0);
    chk("t4_still_full", queue_full_o, 1'b1);
    idle_pop(4);
    chk("t4_drained", instr_valid_o, 1'b0);
    chk("t4_pc", instr_pc_o, 32'h510);

    // Fault propagation and flush-over-push.
    drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
    drive(1, 32'h0000_0013, 32'h600, 0, 1, 0, 0);
    chk("t5_pf", instr_page_fault_o, 1'b1);
    idle_pop(1);
    drive(1, 32'h0000_0013, 32'h700, 0, 0, 0, 1);
    chk("t5_flush_push", instr_valid_o, 1'b0);
    drive(1, 32'h0000_0013, 32'h800, 0, 0, 0, 0);
    chk("t5_reseed", instr_pc_o, 32'h800);
    idle_pop(1);

    // Faulting lone halfword must not deadlock.
    drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
    drive(1, 32'h0013_0000, 32'h902, 0, 1, 0, 0);
    chk("t6_fault_valid", instr_valid_o, 1'b1);
    idle_pop(2);

    // Seed at PC[1]=1 in the non-compressed build.
    drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
    drive(1, 32'h1234_5678, 32'h102, 0, 0, 0, 0);
    chk("t7_mis", instr_misaligned_o, !RVC);
    chk("t7_pc", instr_pc_o, RVC ? 32'h102 : 32'h100);
    idle_pop(2);

    // Streaming with simultaneous push and pop.
    drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++)
      drive(1, tbl[i % 6], 32'hA00 + 4 * i, 0, (i == 7), (i % 3) != 0, 0);
    idle_pop(10);
    chk("t8_drained", instr_valid_o, 1'b0);

    // Reset in the middle of operation.
    drive(1, 32'h0000_0013, 32'hB00, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    chk("t9_valid", instr_valid_o, 1'b0);
    chk("t9_pc", instr_pc_o, 32'h0);
    chk("t9_instr", instr_o, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    drive(1, 32'h0000_0013, 32'h40, 0, 0, 0, 0);
    chk("t9_reseed", instr_pc_o, 32'h40);
    idle_pop(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
